vz16_issue_ctrl: RTL and testbench
==================================

# vz16_issue_ctrl

In-order issue controller for the VZ16 superscalar front-end. It buffers decoded micro-ops from `vz16_decoder` in a small queue and tracks destination-register hazards with a 16-entry scoreboard. It dispatches the oldest ready micro-ops to the ALU and MEM execution ports, up to two per cycle. It sits between decode and the execution units and owns all stall, dispatch and flush sequencing for decoded instructions.

## Interface
- `DEPTH`, 4, queue entries; power of two, 2..16.
- `clk`  in  1  rising-edge clock.
- `nRst`  in  1  asynchronous active-low reset.
- `inValid` / `inReady`  in / out  1 / 1  enqueue handshake from the decoder.
- `inMicroOp` / `inPC`  in  10 / 16  decoded micro-op and instruction address.
- `inRn` / `inR1` / `inR2`  in  4 each  destination register and source registers.
- `flush`  in  1  branch redirect; discards all queued entries.
- `aluValid` / `aluReady`  out / in  1 / 1  ALU-port issue handshake.
- `aluMicroOp` / `aluPC` / `aluRn` / `aluR1` / `aluR2`  out  10/16/4/4/4  ALU-port payload.
- `memValid` / `memReady`  out / in  1 / 1  MEM-port issue handshake.
- `memMicroOp` / `memPC` / `memRn` / `memR1` / `memR2`  out  10/16/4/4/4  MEM-port payload.
- `wbAluValid` / `wbAluReg`  in  1 / 4  ALU writeback; clears the scoreboard bit.
- `wbMemValid` / `wbMemReg`  in  1 / 4  MEM writeback; clears the scoreboard bit.
- `qCount`  out  log2(DEPTH)+1  current queue occupancy.

## Operation
- **Micro-op classes.**
  - Bit 2 (MEM) or bit 3 (STACK) set: routes to the MEM port.
  - Any other op: routes to the ALU port, including branch (bit 1).
  - Bit 1 (BRANCH) clear: the op writes `Rn`.
  - Every op reads `R1` and `R2`.
- **Queue.**
  - Circular FIFO with a head pointer, a tail pointer and a count.
  - `inReady = (qCount != DEPTH)`. It depends only on registered count; there is no same-cycle pass-through.
- **Scoreboard.** `busy[15:0]`.
  - An entry is hazard-free when `busy[R1]`, `busy[R2]` and, if it writes, `busy[Rn]` are all 0. The `Rn` check covers WAW.
- **Slot 0 (head).**
  - Offered when `qCount >= 1` and the head is hazard-free.
  - The valid of its class port is asserted with the head payload.
- **Slot 1 (head+1).** Offered on the other port only when all of the following hold:
  - `qCount >= 2`;
  - slot 0 is offered and its port's ready is 1;
  - slot 1 is of the opposite class;
  - slot 1 is hazard-free;
  - slot 1's `R1`, `R2` and `Rn` do not match slot 0's `Rn` when slot 0 writes.
- **Order and ready rules.**
  - Issue is strictly in order. Slot 1 never issues unless slot 0 issues in the same cycle.
  - Units must not derive ready from valid.
- **Issue.** An op issues on valid&ready.
  - Head advances by the number issued (0, 1 or 2).
  - The `busy[Rn]` of each issued writing op is set.
- **Writeback.** A writeback clears `busy[reg]`.
  - Two writebacks to different registers in one cycle both clear.
  - If an issue sets and a writeback clears the same register in the same cycle, the set wins.
- **No bypass.** A writeback clear becomes visible to the hazard check the following cycle.
- **Enqueue and issue together.** Simultaneous enqueue and issue are allowed: `count_next = count + enq - issued`.
- **Flush.**
  - Force `aluValid = memValid = 0` and ignore `inValid` that cycle.
  - Next cycle: head = tail, `qCount = 0`.
  - The scoreboard is untouched; in-flight ops still write back.

## Timing
- **Reset values.**
  - `qCount = 0` and `inReady = 1`.
  - `aluValid` and `memValid` are 0; all payload outputs are 0.
  - Pointers and `busy` are 0.
  - Reset asserted mid-operation discards queue and scoreboard contents immediately.
- **Latency.**
  - An entry enqueued at edge N is offered at slot 0 in cycle N+1 at the earliest.
  - After a writeback to a blocking register in cycle W, the dependent op is offered in cycle W+1.
- **Output path.** Valid and payload are combinational from registered state plus the other port's ready. There is no internal register stage.
- **Queue full.** With `qCount == DEPTH`, `inReady = 0` even if an issue occurs that cycle.

## Configuration
- `VZ16_DUAL_ISSUE_EN` defined:
  - slot-1 logic is compiled in;
  - up to two ops issue per cycle.
- `VZ16_DUAL_ISSUE_EN` undefined:
  - only slot 0 exists and at most one op issues per cycle;
  - the other port's valid is always 0 while slot 0 is offered;
  - all other behaviour is identical.

## Test plan
1. **Reset and full queue.**
   - Assert `nRst = 0` mid-traffic: expect `qCount = 0`, `inReady = 1`, both valids 0, `busy` = 0.
   - Release reset and enqueue 4 ALU ops with `aluReady = 0`: expect `inReady = 0` after the 4th and a 5th `inValid` not accepted.
2. **RAW stall.**
   - Enqueue ALU `r3<-r1,r2`, then ALU `r5<-r3,r4`, with `aluReady = 1`: the first issues and the second holds `aluValid = 0`.
   - Pulse `wbAluValid` with `wbAluReg = 3` in cycle W: the second issues in W+1.
3. **Dual issue** (macro on).
   - Enqueue ALU `r1<-r2,r4` and MEM `r5<-r6,r7`, both readies 1: both valids are 1 in the same cycle and `qCount` drops 2→0.
   - With the macro off, the same ops issue in consecutive cycles.
4. **Dual blocked.**
   - ALU `r5<-r1,r2` at head, MEM op reading `r5` next: only the ALU op issues.
   - Dual blocked by ready: with `aluReady = 0`, `memValid` stays 0 for a ready MEM op behind the head.
5. **Flush.**
   - 3 entries queued and `r7` busy from an earlier issue; pulse `flush`: `qCount = 0` next cycle and no valids.
   - Enqueue an op reading `r7`: it stalls until `wbMemReg = 7` arrives.
6. **Set/clear collision.**
   - In the same cycle, `wbAluValid` with reg 9 and issue of a new op writing `r9`: `busy[9]` remains 1 afterwards.

Source files
------------

// File: rtl/vz16_issue_ctrl.sv
// In-order issue controller: micro-op queue, 16-entry register scoreboard, ALU/MEM dispatch.
// Optional macro VZ16_DUAL_ISSUE_EN adds the second (head+1) issue slot on the opposite port.
module vz16_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [9:0]               inMicroOp,
  input  logic [15:0]              inPC,
  input  logic [3:0]               inRn,
  input  logic [3:0]               inR1,
  input  logic [3:0]               inR2,
  input  logic                     flush,
  output logic                     aluValid,
  input  logic                     aluReady,
  output logic [9:0]               aluMicroOp,
  output logic [15:0]              aluPC,
  output logic [3:0]               aluRn,
  output logic [3:0]               aluR1,
  output logic [3:0]               aluR2,
  output logic                     memValid,
  input  logic                     memReady,
  output logic [9:0]               memMicroOp,
  output logic [15:0]              memPC,
  output logic [3:0]               memRn,
  output logic [3:0]               memR1,
  output logic [3:0]               memR2,
  input  logic                     wbAluValid,
  input  logic [3:0]               wbAluReg,
  input  logic                     wbMemValid,
  input  logic [3:0]               wbMemReg,
  output logic [$clog2(DEPTH):0]   qCount
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [9:0]  uop;
    logic [15:0] pc;
    logic [3:0]  rn;
    logic [3:0]  r1;
    logic [3:0]  r2;
  } entry_t;

  entry_t        q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic [15:0]   busy, busy_next;

  entry_t      e0, e1, alu_e, mem_e;
  logic        s0_ok, s0_mem, s0_fire, s1_ok, s1_fire, enq;
  logic [1:0]  n_issue;

  function automatic logic is_mem(entry_t e);
    return e.uop[2] | e.uop[3];
  endfunction

  function automatic logic writes(entry_t e);
    return ~e.uop[1];
  endfunction

  function automatic logic hazard_free(entry_t e, logic [15:0] b);
    return !b[e.r1] && !b[e.r2] && !(writes(e) && b[e.rn]);
  endfunction

  assign inReady = (count != (PW+1)'(DEPTH));
  assign qCount  = count;
  assign enq     = inValid && inReady && !flush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    e0      = q[head];
    e1      = q[head + PW'(1)];
    s0_ok   = (count != '0) && !flush && hazard_free(e0, busy);
    s0_mem  = is_mem(e0);
    s0_fire = s0_ok && (s0_mem ? memReady : aluReady);
`ifdef VZ16_DUAL_ISSUE_EN
    // Slot 1 rides only on a slot-0 issue, so in-order issue is preserved.
    s1_ok   = (count >= (PW+1)'(2)) && s0_fire && (is_mem(e1) != s0_mem) &&
              hazard_free(e1, busy) &&
              !(writes(e0) && (e1.r1 == e0.rn || e1.r2 == e0.rn || e1.rn == e0.rn));
`else
    s1_ok   = 1'b0;
`endif
    s1_fire = s1_ok && (s0_mem ? aluReady : memReady);
    n_issue = {1'b0, s0_fire} + {1'b0, s1_fire};

    aluValid = 1'b0;
    memValid = 1'b0;
    alu_e    = '0;
    mem_e    = '0;
    if (s0_ok) begin
      if (s0_mem) begin memValid = 1'b1; mem_e = e0; end
      else        begin aluValid = 1'b1; alu_e = e0; end
    end
    if (s1_ok) begin
      if (s0_mem) begin aluValid = 1'b1; alu_e = e1; end
      else        begin memValid = 1'b1; mem_e = e1; end
    end

    // Issue sets are applied after writeback clears so a same-cycle set wins.
    busy_next = busy;
    if (wbAluValid) busy_next[wbAluReg] = 1'b0;
    if (wbMemValid) busy_next[wbMemReg] = 1'b0;
    if (s0_fire && writes(e0)) busy_next[e0.rn] = 1'b1;
    if (s1_fire && writes(e1)) busy_next[e1.rn] = 1'b1;
  end

  assign aluMicroOp = alu_e.uop;
  assign aluPC      = alu_e.pc;
  assign aluRn      = alu_e.rn;
  assign aluR1      = alu_e.r1;
  assign aluR2      = alu_e.r2;
  assign memMicroOp = mem_e.uop;
  assign memPC      = mem_e.pc;
  assign memRn      = mem_e.rn;
  assign memR1      = mem_e.r1;
  assign memR2      = mem_e.r2;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
    end else begin
      busy <= busy_next;
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        head  <= head + PW'(n_issue);
        if (enq) tail <= tail + PW'(1);
        count <= count + (PW+1)'(enq) - (PW+1)'(n_issue);
      end
    end
  end

  // NOTE: queue storage has no reset; outputs are zero-gated by valid, so stale data never shows.
  always_ff @(posedge clk) begin
    if (enq) q[tail] <= '{uop: inMicroOp, pc: inPC, rn: inRn, r1: inR1, r2: inR2};
  end

endmodule

// File: tb/tb_vz16_issue_ctrl.sv
// Randomized bench for vz16_issue_ctrl against a queue-based reference model of the issue rules.
module tb_vz16_issue_ctrl;

  localparam int DEPTH = 4;
`ifdef VZ16_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  uop;
    logic [15:0] pc;
    logic [3:0]  rn;
    logic [3:0]  r1;
    logic [3:0]  r2;
  } op_t;

  logic clk = 1'b0;
  logic nRst;
  logic inValid, inReady, flush;
  logic [9:0] inMicroOp;
  logic [15:0] inPC;
  logic [3:0] inRn, inR1, inR2;
  logic aluValid, aluReady, memValid, memReady;
  logic [9:0] aluMicroOp, memMicroOp;
  logic [15:0] aluPC, memPC;
  logic [3:0] aluRn, aluR1, aluR2, memRn, memR1, memR2;
  logic wbAluValid, wbMemValid;
  logic [3:0] wbAluReg, wbMemReg;
  logic [$clog2(DEPTH):0] qCount;

  vz16_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .nRst(nRst),
    .inValid(inValid), .inReady(inReady),
    .inMicroOp(inMicroOp), .inPC(inPC), .inRn(inRn), .inR1(inR1), .inR2(inR2),
    .flush(flush),
    .aluValid(aluValid), .aluReady(aluReady),
    .aluMicroOp(aluMicroOp), .aluPC(aluPC), .aluRn(aluRn), .aluR1(aluR1), .aluR2(aluR2),
    .memValid(memValid), .memReady(memReady),
    .memMicroOp(memMicroOp), .memPC(memPC), .memRn(memRn), .memR1(memR1), .memR2(memR2),
    .wbAluValid(wbAluValid), .wbAluReg(wbAluReg),
    .wbMemValid(wbMemValid), .wbMemReg(wbMemReg),
    .qCount(qCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an in-order list of pending ops and the set of busy registers.
  op_t         mq[$];
  logic [15:0] mbusy;

  int p_valid, p_ready, p_flush, p_wb, rmax;

  logic e_alu_v, e_mem_v;
  op_t  e_alu, e_mem;
  op_t  iss[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mem_class(op_t o);  return o.uop[2] || o.uop[3]; endfunction
  function automatic bit writer(op_t o);     return !o.uop[1];            endfunction
  function automatic bit ready_for(op_t o);
    return mem_class(o) ? memReady : aluReady;
  endfunction
  function automatic bit no_hazard(op_t o);
    return !mbusy[o.r1] && !mbusy[o.r2] && !(writer(o) && mbusy[o.rn]);
  endfunction

  function automatic logic [3:0] pick_wb();
    logic [3:0] r;
    r = 4'($urandom_range(15));
    if ($urandom_range(99) < 30) return r;
    for (int t = 0; t < 12; t++) begin
      if (mbusy[r]) return r;
      r = 4'($urandom_range(15));
    end
    return r;
  endfunction

  // Decide what the model expects on the ports this cycle and which ops leave the queue.
  task automatic predict();
    op_t h0, h1;
    bit  go0, go1;
    e_alu_v = 1'b0; e_mem_v = 1'b0; e_alu = '0; e_mem = '0;
    iss.delete();
    if (mq.size() >= 1 && !flush && no_hazard(mq[0])) begin
      h0 = mq[0];
      if (mem_class(h0)) begin e_mem_v = 1'b1; e_mem = h0; end
      else               begin e_alu_v = 1'b1; e_alu = h0; end
      go0 = ready_for(h0);
      if (go0) iss.push_back(h0);
      if (DUAL && go0 && mq.size() >= 2) begin
        h1 = mq[1];
        if (mem_class(h1) != mem_class(h0) && no_hazard(h1) &&
            !(writer(h0) && (h1.r1 == h0.rn || h1.r2 == h0.rn || h1.rn == h0.rn))) begin
          if (mem_class(h1)) begin e_mem_v = 1'b1; e_mem = h1; end
          else               begin e_alu_v = 1'b1; e_alu = h1; end
          go1 = ready_for(h1);
          if (go1) iss.push_back(h1);
        end
      end
    end
  endtask

  task automatic compare();
    check("qCount",   qCount,   64'(mq.size()));
    check("inReady",  inReady,  64'(mq.size() != DEPTH));
    check("aluValid", aluValid, 64'(e_alu_v));
    check("memValid", memValid, 64'(e_mem_v));
    check("busy",     dut.busy, 64'(mbusy));
    if (e_alu_v) check("aluPayload", {aluMicroOp, aluPC, aluRn, aluR1, aluR2}, 64'(e_alu));
    if (e_mem_v) check("memPayload", {memMicroOp, memPC, memRn, memR1, memR2}, 64'(e_mem));
  endtask

  task automatic step();
    int  sz;
    op_t nin;
    @(negedge clk);
    inValid    = ($urandom_range(99) < p_valid);
    inMicroOp  = 10'($urandom);
    inPC       = 16'($urandom);
    inRn       = 4'($urandom_range(rmax - 1));
    inR1       = 4'($urandom_range(rmax - 1));
    inR2       = 4'($urandom_range(rmax - 1));
    flush      = ($urandom_range(99) < p_flush);
    aluReady   = ($urandom_range(99) < p_ready);
    memReady   = ($urandom_range(99) < p_ready);
    wbAluValid = ($urandom_range(99) < p_wb);
    wbAluReg   = pick_wb();
    wbMemValid = ($urandom_range(99) < p_wb);
    wbMemReg   = pick_wb();
    #1;
    predict();
    compare();
    @(posedge clk);
    sz  = mq.size();
    nin = '{uop: inMicroOp, pc: inPC, rn: inRn, r1: inR1, r2: inR2};
    if (flush) mq.delete();
    else begin
      for (int i = 0; i < iss.size(); i++) void'(mq.pop_front());
      if (inValid && sz != DEPTH) mq.push_back(nin);
    end
    if (wbAluValid) mbusy[wbAluReg] = 1'b0;
    if (wbMemValid) mbusy[wbMemReg] = 1'b0;
    foreach (iss[i]) if (writer(iss[i])) mbusy[iss[i].rn] = 1'b1;
  endtask

  task automatic quiet_inputs();
    inValid = 0; flush = 0; aluReady = 0; memReady = 0;
    wbAluValid = 0; wbMemValid = 0; wbAluReg = 0; wbMemReg = 0;
    inMicroOp = 0; inPC = 0; inRn = 0; inR1 = 0; inR2 = 0;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_qCount"},   qCount,   64'd0);
    check({tag, "_inReady"},  inReady,  64'd1);
    check({tag, "_aluValid"}, aluValid, 64'd0);
    check({tag, "_memValid"}, memValid, 64'd0);
    check({tag, "_aluPayload"}, {aluMicroOp, aluPC, aluRn, aluR1, aluR2}, 64'd0);
    check({tag, "_memPayload"}, {memMicroOp, memPC, memRn, memR1, memR2}, 64'd0);
    check({tag, "_busy"},     dut.busy, 64'd0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    quiet_inputs();
    nRst = 1'b0;
    #1;
    mq.delete();
    mbusy = '0;
    reset_check("midreset");
    @(negedge clk);
    nRst = 1'b1;
  endtask

  initial begin
    quiet_inputs();
    mbusy = '0;
    nRst  = 1'b0;
    #12;
    reset_check("reset");
    @(negedge clk);
    nRst = 1'b1;

    // Fill with nothing ready: queue saturates and extra enqueues are refused.
    p_valid = 100; p_ready = 0; p_flush = 0; p_wb = 0; rmax = 16;
    repeat (8) step();

    // Heavy hazards on a few registers.
    p_valid = 60; p_ready = 70; p_flush = 3; p_wb = 40; rmax = 4;
    repeat (800) step();

    // Traffic interrupted by reset.
    mid_reset();
    rmax = 16;
    repeat (800) step();

    // Mostly ready ports to exercise back-to-back and dual issue.
    p_ready = 95; p_valid = 80; rmax = 8;
    repeat (800) step();

    mid_reset();
    p_ready = 50; p_flush = 8; rmax = 6;
    repeat (400) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
